// File: rtl/core_pkg.sv
// Shared core types and data-memory map used by the data-memory responder.
package core;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;

  localparam word_t DATA_BASE = 32'h0000_1000;
  localparam word_t DATA_SIZE = 32'h0000_1000;

  typedef struct packed {
    word_t addr;
    logic  write;
    word_t wdata;
    strb_t strb;
  } dreq_t;

  typedef struct packed {
    word_t data;
    logic  error;
  } drsp_t;
endpackage

// File: rtl/data_responder_if.sv
// Data-memory request/response bus between the core (master) and a responder (slave).
interface data_responder_if;
  import core::*;

  logic  req_valid;
  logic  req_ready;
  word_t req_addr;
  logic  req_write;
  word_t req_wdata;
  strb_t req_strb;
  logic  rsp_valid;
  logic  rsp_ready;
  word_t rsp_data;
  logic  rsp_error;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_error
  );
  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/data_ram.sv
// Single-port word RAM with byte enables, read enable and registered read data.
module data_ram
  import core::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  strb_t         strb,
  input  word_t         wdata,
  output word_t         rdata
);
  logic [3:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) mem[addr][i] <= wdata[i*8 +: 8];
    end
    // Output register only moves on a read, so a stalled response keeps its data.
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/data_responder.sv
// Responder for the core's data-memory bus: decode, one-deep response FSM, RAM access.
module data_responder
  import core::*;
#(
  parameter word_t BASE = DATA_BASE,
  parameter word_t SIZE = DATA_SIZE
) (
  input  logic clk,
  input  logic resetn,
  data_responder_if.slave bus
);
  localparam int DEPTH = int'(SIZE / 4);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_nxt;
  dreq_t  req;
  drsp_t  rsp;
  word_t  offset, ram_rdata;
  logic   in_range, aligned, fault, accept, ram_we, ram_re;
  logic   is_load_q, fault_q;

  assign req = '{addr: bus.req_addr, write: bus.req_write,
                 wdata: bus.req_wdata, strb: bus.req_strb};

  // Unsigned offset compare rejects addresses below BASE without wrap aliasing.
  assign offset   = req.addr - BASE;
  assign in_range = offset < SIZE;
  assign aligned  = req.addr[1:0] == 2'b00;
  assign fault    = !in_range || !aligned;

  assign bus.rsp_valid = (state == RESP);
  assign bus.req_ready = !bus.rsp_valid || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;
  assign ram_we        = resetn && accept && req.write && !fault;
  assign ram_re        = resetn && accept && !req.write && !fault;

  data_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (AW'(offset >> 2)),
    .strb  (req.strb),
    .wdata (req.wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      is_load_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_load_q <= !req.write && !fault;
        fault_q   <= fault;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RESP;
      RESP: if (accept) state_nxt = RESP;
            else if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp.data  = is_load_q ? ram_rdata : '0;
  assign rsp.error = fault_q;

  assign bus.rsp_data  = rsp.data;
  assign bus.rsp_error = rsp.error;
endmodule

// File: tb/tb_data_responder.sv
// Directed-vector bench for data_responder with hand-computed expected responses.
module tb_data_responder;
  import core::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_responder_if dif();

  data_responder dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dif.slave)
  );

  logic [31:0] q_addr[$], q_wdata[$], q_edata[$];
  logic        q_write[$], q_eerr[$];
  strb_t       q_strb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input strb_t s, input logic [31:0] ed, input logic ee);
    q_write.push_back(w); q_addr.push_back(a); q_wdata.push_back(d);
    q_strb.push_back(s);  q_edata.push_back(ed); q_eerr.push_back(ee);
  endtask

  // Streams queued requests back to back; response k is checked while request k+1 is driven.
  task automatic flush(input string tag);
    int n = q_addr.size();
    dif.rsp_ready = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("%s[%0d].valid", tag, k-1), {31'b0, dif.rsp_valid}, 32'd1);
        chk($sformatf("%s[%0d].data", tag, k-1), dif.rsp_data, q_edata[k-1]);
        chk($sformatf("%s[%0d].err", tag, k-1), {31'b0, dif.rsp_error}, {31'b0, q_eerr[k-1]});
      end
      if (k < n) begin
        chk($sformatf("%s[%0d].ready", tag, k), {31'b0, dif.req_ready}, 32'd1);
        dif.req_valid = 1'b1;
        dif.req_write = q_write[k];
        dif.req_addr  = q_addr[k];
        dif.req_wdata = q_wdata[k];
        dif.req_strb  = q_strb[k];
      end else begin
        dif.req_valid = 1'b0;
      end
    end
    q_addr.delete(); q_wdata.delete(); q_edata.delete();
    q_write.delete(); q_eerr.delete(); q_strb.delete();
    @(negedge clk);
    chk({tag, ".drained"}, {31'b0, dif.rsp_valid}, 32'd0);
  endtask

  initial begin
    dif.req_valid = 1'b0; dif.req_write = 1'b0; dif.req_addr = '0;
    dif.req_wdata = '0;   dif.req_strb  = '0;   dif.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.valid", {31'b0, dif.rsp_valid}, 32'd0);
    chk("rst.err",   {31'b0, dif.rsp_error}, 32'd0);
    chk("rst.data",  dif.rsp_data, 32'd0);
    chk("rst.ready", {31'b0, dif.req_ready}, 32'd1);
    resetn = 1'b1;

    // Basic store then load
    add(1, 32'h1000, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    add(0, 32'h1000, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    flush("basic");

    // Byte strobes, including a no-op zero-strobe store
    add(1, 32'h1004, 32'h11223344, 4'hF, 32'h0, 0);
    add(1, 32'h1004, 32'h00AA0000, 4'h4, 32'h0, 0);
    add(1, 32'h1004, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
    add(0, 32'h1004, 32'h0, 4'h0, 32'h11AA3344, 0);
    flush("strb");

    // Faults: below, above, misaligned, wrapped; memory left intact
    add(0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1);
    add(0, 32'h2000, 32'h0, 4'h0, 32'h0, 1);
    add(1, 32'h1002, 32'h12345678, 4'hF, 32'h0, 1);
    add(0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 1);
    add(0, 32'h1000, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    flush("fault");

    // Backpressure: response held while a second request waits unaccepted
    @(negedge clk);
    dif.rsp_ready = 1'b0;
    dif.req_valid = 1'b1; dif.req_write = 1'b0; dif.req_addr = 32'h1000;
    @(negedge clk);
    dif.req_addr = 32'h1004;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp[%0d].valid", i), {31'b0, dif.rsp_valid}, 32'd1);
      chk($sformatf("bp[%0d].data", i), dif.rsp_data, 32'hDEADBEEF);
      chk($sformatf("bp[%0d].ready", i), {31'b0, dif.req_ready}, 32'd0);
      @(negedge clk);
    end
    dif.req_valid = 1'b0;
    dif.rsp_ready = 1'b1;
    chk("bp.rel.valid", {31'b0, dif.rsp_valid}, 32'd1);
    chk("bp.rel.data",  dif.rsp_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("bp.once0", {31'b0, dif.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("bp.once1", {31'b0, dif.rsp_valid}, 32'd0);

    // Streaming read-after-write at the top of the region
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, d;
      a = (i % 2) ? 32'h1FFC : 32'h1FF8;
      d = 32'hA500_0000 + 32'(i) * 32'h0101_0101;
      add(1, a, d, 4'hF, 32'h0, 0);
      add(0, a, 32'h0, 4'h0, d, 0);
    end
    add(0, 32'h2000, 32'h0, 4'h0, 32'h0, 1);
    flush("stream");

    // Reset with a stalled response; a store during reset must not land
    @(negedge clk);
    dif.rsp_ready = 1'b0;
    dif.req_valid = 1'b1; dif.req_write = 1'b0; dif.req_addr = 32'h1000;
    @(negedge clk);
    dif.req_valid = 1'b0;
    chk("mrst.pre", {31'b0, dif.rsp_valid}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mrst.valid", {31'b0, dif.rsp_valid}, 32'd0);
    chk("mrst.data",  dif.rsp_data, 32'd0);
    chk("mrst.err",   {31'b0, dif.rsp_error}, 32'd0);
    chk("mrst.ready", {31'b0, dif.req_ready}, 32'd1);
    dif.req_valid = 1'b1; dif.req_write = 1'b1; dif.req_addr = 32'h1000;
    dif.req_wdata = 32'h0; dif.req_strb = 4'hF;
    @(negedge clk);
    dif.req_valid = 1'b0;
    resetn = 1'b1;
    add(0, 32'h1000, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    flush("mrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
